// File: rtl/multicycle_control.sv
// Multicycle RISC-V control unit: Moore FSM sequencing fetch, decode, memory,
// ALU and branch steps, plus ALUControl and ImmSrc decode. An optional memory
// handshake (MemReady) stretches FETCH, MEMREAD and MEMWRITE.
module multicycle_control #(
  parameter int unsigned MEM_WAIT_EN = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       Illegal
);

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecR,
    StExecI,
    StAluWb,
    StBeq,
    StJal,
    StTrap
  } state_e;

  typedef enum logic [1:0] {
    AluOpAdd,
    AluOpSub,
    AluOpFunct
  } alu_op_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  state_e     r_state;
  state_e     w_state_next;
  alu_op_e    w_alu_op;
  logic       w_mem_ready;

  // Ungated datapath enables; the write strobes are masked by reset below.
  logic       w_pc_write;
  logic       w_ir_write;
  logic       w_mem_write;
  logic       w_reg_write;
  logic       w_illegal;

  // With the wait feature disabled every memory access completes in one cycle.
  assign w_mem_ready = (MEM_WAIT_EN != 0) ? MemReady : 1'b1;

  // State register; reset aborts whatever instruction is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StFetch;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state sequencing.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StFetch: begin
        if (w_mem_ready) w_state_next = StDecode;
      end
      StDecode: begin
        unique case (op)
          OpLoad, OpStore: w_state_next = StMemAdr;
          OpRType:         w_state_next = StExecR;
          OpIType:         w_state_next = StExecI;
          OpBranch:        w_state_next = StBeq;
          OpJal:           w_state_next = StJal;
          default:         w_state_next = StTrap;
        endcase
      end
      StMemAdr:   w_state_next = op[5] ? StMemWrite : StMemRead;
      StMemRead: begin
        if (w_mem_ready) w_state_next = StMemWb;
      end
      StMemWb:    w_state_next = StFetch;
      StMemWrite: begin
        if (w_mem_ready) w_state_next = StFetch;
      end
      StExecR:    w_state_next = StAluWb;
      StExecI:    w_state_next = StAluWb;
      StAluWb:    w_state_next = StFetch;
      StBeq:      w_state_next = StFetch;
      StJal:      w_state_next = StAluWb;
      StTrap:     w_state_next = StTrap;
      default:    w_state_next = StFetch;
    endcase
  end

  // Per-state datapath controls; anything not driven by a state stays 0.
  always_comb begin
    w_pc_write  = 1'b0;
    w_ir_write  = 1'b0;
    w_mem_write = 1'b0;
    w_reg_write = 1'b0;
    w_illegal   = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    w_alu_op    = AluOpAdd;
    unique case (r_state)
      StFetch: begin
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        // PC+4 and the instruction latch only once memory has delivered.
        w_ir_write = w_mem_ready;
        w_pc_write = w_mem_ready;
      end
      StDecode: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      StMemAdr: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      StMemRead: begin
        AdrSrc = 1'b1;
      end
      StMemWb: begin
        ResultSrc   = 2'b01;
        w_reg_write = 1'b1;
      end
      StMemWrite: begin
        AdrSrc      = 1'b1;
        w_mem_write = 1'b1;
      end
      StExecR: begin
        ALUSrcA  = 2'b10;
        w_alu_op = AluOpFunct;
      end
      StExecI: begin
        ALUSrcA  = 2'b10;
        ALUSrcB  = 2'b01;
        w_alu_op = AluOpFunct;
      end
      StAluWb: begin
        w_reg_write = 1'b1;
      end
      StBeq: begin
        ALUSrcA    = 2'b10;
        w_alu_op   = AluOpSub;
        w_pc_write = Zero;
      end
      StJal: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        w_pc_write = 1'b1;
      end
      StTrap: begin
        w_illegal = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU function select; only R-type (op[5]=1) can request subtract via funct7.
  always_comb begin
    ALUControl = 3'b000;
    unique case (w_alu_op)
      AluOpAdd: ALUControl = 3'b000;
      AluOpSub: ALUControl = 3'b001;
      AluOpFunct: begin
        unique case (funct3)
          3'b000:  ALUControl = (funct7_5 & op[5]) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  // Immediate format follows the opcode alone, independent of state.
  always_comb begin
    ImmSrc = 2'b00;
    unique case (op)
      OpStore:  ImmSrc = 2'b01;
      OpBranch: ImmSrc = 2'b10;
      OpJal:    ImmSrc = 2'b11;
      default:  ImmSrc = 2'b00;
    endcase
  end

  // Reset masks all write strobes combinationally, whatever MemReady does.
  assign PCWrite  = rst_n & w_pc_write;
  assign IRWrite  = rst_n & w_ir_write;
  assign MemWrite = rst_n & w_mem_write;
  assign RegWrite = rst_n & w_reg_write;
  assign Illegal  = rst_n & w_illegal;

endmodule
